fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Owns the PC and issues one instruction-memory request at a time over a grant/response handshake. Drives the IF/ID register's write enable, next-PC and instruction inputs. Handles hazard-unit stalls and redirects from branch/jump/exception resolution, inserting NOP bubbles when no valid instruction is available.

## Interface
- RESET_PC, 32'h0000_1000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word driven into IF/ID for bubbles
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: IF/ID must hold its contents
- redirect  in  1  taken branch/jump/exception; flush and refetch
- redirect_pc  in  32  target PC, valid when redirect=1
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (byte address, 4-aligned)
- imem_gnt  in  1  request accepted this cycle (when imem_req=1)
- imem_rvalid  in  1  response data valid; at least 1 cycle after grant
- imem_rdata  in  32  instruction word
- if_id_write  out  1  write enable to IF/ID register
- next_PC_out  out  32  PC+4 of delivered instruction, 0 for bubble
- ir_out  out  32  delivered instruction, NOP_INSTR for bubble

## Operation
- Registers: pc (32), state (2 bits), ir_buf (32).
- At most one outstanding memory request. imem_addr = pc whenever imem_req=1; it holds stable until granted unless a redirect arrives.
- States:
  - REQ: imem_req=1. On gnt, go to WAIT. A redirect without gnt sets pc<=redirect_pc and stays in REQ. A redirect together with gnt sets pc<=redirect_pc and goes to DROP, because the granted request belongs to the old path.
  - WAIT: imem_req=0, waiting for rvalid.
    - rvalid and redirect: discard the data, pc<=redirect_pc, go to REQ.
    - rvalid, no stall: deliver imem_rdata, pc<=pc+4, go to REQ.
    - rvalid and stall: ir_buf<=imem_rdata, go to HOLD.
    - redirect without rvalid: pc<=redirect_pc, go to DROP.
  - HOLD: imem_req=0; the instruction is buffered.
    - redirect: discard the buffer, pc<=redirect_pc, go to REQ.
    - no stall: deliver ir_buf, pc<=pc+4, go to REQ.
  - DROP: imem_req=0. On rvalid, discard the data and go to REQ. A redirect in DROP updates pc and stays in DROP; a simultaneous rvalid still goes to REQ with the new pc.
- if_id_write = ~reset & (redirect | ~stall). Redirect overrides stall.
- deliver = ((WAIT & rvalid) | HOLD) & ~stall & ~redirect.
- When deliver=1: ir_out = data (imem_rdata in WAIT, ir_buf in HOLD) and next_PC_out = pc+4.
- Otherwise: ir_out = NOP_INSTR and next_PC_out = 0. When if_id_write=1 this loads a bubble.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag. redirect_pc[1:0] is ignored and forced to 0.

## Timing
- While reset=1: imem_req=0, if_id_write=0, ir_out=NOP_INSTR, next_PC_out=0. After the edge: state=REQ, pc=RESET_PC, ir_buf=NOP_INSTR.
- First request: imem_req=1 in the first cycle after reset deasserts.
- Best-case throughput, with gnt in the REQ cycle and rvalid one cycle later: one instruction per 2 cycles. Delivery happens in the rvalid cycle and is captured by IF/ID at that edge.
- Outputs to IF/ID are combinational from state, registers and imem inputs. imem_req and imem_addr are combinational from state and pc only.
- A redirect takes effect on the next edge; the first request to redirect_pc is issued in the next REQ cycle.
- Reset mid-operation returns the unit to the reset state. The memory shares the same reset and must drop outstanding responses; any rvalid arriving in REQ is ignored.

## Test plan
- Reset, then gnt=1 immediately and rvalid next cycle with rdata=32'hAAAA0001 -> first imem_addr=0x1000; if_id_write=1, ir_out=32'hAAAA0001, next_PC_out=0x1004; next imem_addr=0x1004.
- gnt held low for 3 cycles, rvalid 4 cycles after gnt -> imem_addr stable at 0x1000 throughout; bubbles (NOP_INSTR, 0) each non-delivery cycle with stall=0; a single delivery.
- stall=1 as rvalid arrives with 32'hBBBB0002, stall held 3 cycles -> if_id_write=0 for those cycles; on release, ir_out=32'hBBBB0002 from ir_buf and next_PC_out=pc+4; exactly one delivery.
- redirect=1 with redirect_pc=0x2000 while in WAIT; stale rvalid 2 cycles later -> stale data never delivered; if_id_write=1 with NOP on the redirect cycle; next imem_addr=0x2000.
- redirect together with stall=1 in HOLD -> if_id_write=1, ir_out=NOP_INSTR; buffer discarded; next request to 0x2000.
- pc=32'hFFFF_FFFC delivered -> next_PC_out=0, next imem_addr=0; reset asserted during WAIT -> next cycle state=REQ, imem_addr=0x1000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// feeds the IF/ID register, inserting NOP bubbles when nothing valid is ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_write,
    output logic [31:0] next_PC_out,
    output logic [31:0] ir_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ir_buf;
    logic [31:0] w_ir_buf_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_deliver;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

    assign imem_req  = ~reset & (r_state == S_REQ);
    assign imem_addr = r_pc;

    // Redirect overrides stall so the flush bubble always reaches IF/ID.
    assign if_id_write = ~reset & (redirect | ~stall);
    assign w_deliver   = ~reset & ~stall & ~redirect &
                         (((r_state == S_WAIT) & imem_rvalid) | (r_state == S_HOLD));

    always_comb begin
        ir_out      = NOP_INSTR;
        next_PC_out = '0;
        if (w_deliver) begin
            ir_out      = (r_state == S_HOLD) ? r_ir_buf : imem_rdata;
            next_PC_out = w_pc_plus4;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_buf_nxt = r_ir_buf;
        case (r_state)
            S_REQ: begin
                if (redirect) w_pc_nxt = w_redirect_pc;
                if (imem_gnt) w_state_nxt = redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        w_pc_nxt    = w_redirect_pc;
                        w_state_nxt = S_REQ;
                    end else if (!stall) begin
                        w_pc_nxt    = w_pc_plus4;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_ir_buf_nxt = imem_rdata;
                        w_state_nxt  = S_HOLD;
                    end
                end else if (redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect)    w_pc_nxt = w_redirect_pc;
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_ir_buf <= NOP_INSTR;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir_buf <= w_ir_buf_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-driven grant/response handshake with
// hand-computed expectations for every delivery, bubble and redirect case.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_write;
    logic [31:0] next_PC_out;
    logic [31:0] ir_out;

    int unsigned n_checks;
    int unsigned n_errors;

    fetch_unit #(
        .RESET_PC  (32'h0000_1000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_write (if_id_write),
        .next_PC_out (next_PC_out),
        .ir_out      (ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs settle, then sample well away from the edge.
    task automatic settle();
        #2;
    endtask

    task automatic bubble(input string tag);
        chk({tag, ".wr"},  {31'd0, if_id_write}, 32'd1);
        chk({tag, ".ir"},  ir_out, NOP);
        chk({tag, ".npc"}, next_PC_out, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        tick();
        stall = 1'b0; settle();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.wr",  {31'd0, if_id_write}, 32'd0);
        chk("rst.ir",  ir_out, NOP);
        chk("rst.npc", next_PC_out, 32'd0);
        tick();

        // First fetch: grant immediately, data next cycle.
        reset = 1'b0; imem_gnt = 1'b1; settle();
        chk("f1.req",  {31'd0, imem_req}, 32'd1);
        chk("f1.addr", imem_addr, 32'h0000_1000);
        bubble("f1.req_cyc");
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; settle();
        chk("f1.wait_req", {31'd0, imem_req}, 32'd0);
        chk("f1.wr",  {31'd0, if_id_write}, 32'd1);
        chk("f1.ir",  ir_out, 32'hAAAA_0001);
        chk("f1.npc", next_PC_out, 32'h0000_1004);
        tick();

        // Grant withheld three cycles, response four cycles after grant.
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("f2.addr", imem_addr, 32'h0000_1004);
            chk("f2.req",  {31'd0, imem_req}, 32'd1);
            bubble("f2.nogrant");
            tick();
        end
        imem_gnt = 1'b1; settle();
        chk("f2.addr_g", imem_addr, 32'h0000_1004);
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("f2.wait_req", {31'd0, imem_req}, 32'd0);
            bubble("f2.wait");
            tick();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0003; settle();
        chk("f2.ir",  ir_out, 32'hCCCC_0003);
        chk("f2.npc", next_PC_out, 32'h0000_1008);
        tick();

        // Stall on arrival: buffer the word, deliver it on release.
        imem_rvalid = 1'b0; imem_gnt = 1'b1; settle();
        chk("f3.addr", imem_addr, 32'h0000_1008);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002; stall = 1'b1; settle();
        chk("f3.wr0", {31'd0, if_id_write}, 32'd0);
        chk("f3.ir0", ir_out, NOP);
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("f3.wr_hold", {31'd0, if_id_write}, 32'd0);
            chk("f3.req_hold", {31'd0, imem_req}, 32'd0);
            tick();
        end
        stall = 1'b0; settle();
        chk("f3.wr",  {31'd0, if_id_write}, 32'd1);
        chk("f3.ir",  ir_out, 32'hBBBB_0002);
        chk("f3.npc", next_PC_out, 32'h0000_100C);
        tick();
        settle();
        chk("f3.next_addr", imem_addr, 32'h0000_100C);
        chk("f3.no_redeliver", ir_out, NOP);

        // Redirect in WAIT, then a stale response must be dropped.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2000; settle();
        bubble("f4.redir");
        tick();
        redirect = 1'b0; settle();
        chk("f4.drop_req", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h5A5A_5A5A; settle();
        bubble("f4.stale");
        tick();
        imem_rvalid = 1'b0; settle();
        chk("f4.req",  {31'd0, imem_req}, 32'd1);
        chk("f4.addr", imem_addr, 32'h0000_2000);

        // Redirect together with stall while HOLD; low PC bits forced to zero.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_0005; stall = 1'b1;
        tick();
        imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_3003; settle();
        bubble("f5.redir_stall");
        tick();
        redirect = 1'b0; stall = 1'b0; settle();
        chk("f5.req",  {31'd0, imem_req}, 32'd1);
        chk("f5.addr", imem_addr, 32'h0000_3000);
        chk("f5.ir",   ir_out, NOP);

        // Stall in REQ blocks IF/ID writes but not the request.
        stall = 1'b1; settle();
        chk("f5.stall_wr", {31'd0, if_id_write}, 32'd0);
        chk("f5.stall_req", {31'd0, imem_req}, 32'd1);
        stall = 1'b0;

        // Redirect in REQ without grant, then PC wraparound.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
        chk("f6.addr_old", imem_addr, 32'h0000_3000);
        tick();
        redirect = 1'b0; imem_gnt = 1'b1; settle();
        chk("f6.addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h7777_0007; settle();
        chk("f6.ir",  ir_out, 32'h7777_0007);
        chk("f6.npc", next_PC_out, 32'h0000_0000);
        tick();
        imem_rvalid = 1'b0; settle();
        chk("f6.wrap_addr", imem_addr, 32'h0000_0000);

        // Redirect with grant goes to DROP; a second redirect there wins.
        imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_4000;
        tick();
        imem_gnt = 1'b0; redirect_pc = 32'h0000_5000; imem_rvalid = 1'b1; imem_rdata = 32'h9999_0009; settle();
        chk("f7.req", {31'd0, imem_req}, 32'd0);
        bubble("f7.drop");
        tick();
        redirect = 1'b0; imem_rvalid = 1'b0; settle();
        chk("f7.addr", imem_addr, 32'h0000_5000);
        chk("f7.req2", {31'd0, imem_req}, 32'd1);

        // Reset during WAIT; later stale rvalid in REQ is ignored.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; reset = 1'b1; settle();
        chk("f8.rst_wr",  {31'd0, if_id_write}, 32'd0);
        chk("f8.rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hEEEE_000E; settle();
        chk("f8.req",  {31'd0, imem_req}, 32'd1);
        chk("f8.addr", imem_addr, 32'h0000_1000);
        bubble("f8.ignore");
        tick();
        imem_rvalid = 1'b0; settle();
        chk("f8.still_req", {31'd0, imem_req}, 32'd1);
        chk("f8.addr2", imem_addr, 32'h0000_1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
